// File: rtl/xaui_pkg.sv
`default_nettype none
// xaui_pkg: XGMII/XAUI code constants, lane/column index helpers and the per-column
// idle-to-||A||/||K||/||R|| mapper shared by xaui_tx_idle_gen.
package xaui_pkg;

   localparam logic [7:0] CODE_IDLE = 8'h07;
   localparam logic [7:0] CODE_A    = 8'h7C;
   localparam logic [7:0] CODE_K    = 8'hBC;
   localparam logic [7:0] CODE_R    = 8'h1C;
   localparam logic [7:0] CODE_S    = 8'hFB;
   localparam logic [7:0] CODE_T    = 8'hFD;
   localparam logic [7:0] CODE_Q    = 8'h9C;
   localparam logic [7:0] CODE_E    = 8'hFE;

   localparam int LANES = 4;
   localparam int COLS  = 2;

   typedef struct packed {
      logic [31:0] bytes;
      logic [3:0]  k;
      logic [4:0]  a_next;
      logic        a_sent;
   } col_res_t;

   // Bit offset of lane l, column c on the XGMII side.
   function automatic int txd_pos(input int c, input int l);
      return c * 32 + l * 8;
   endfunction

   // Bit offset of lane l, column c on the MGT side; steer reverses lane order.
   function automatic int out_byte_pos(input int l, input int c, input bit steer);
      return (steer ? (LANES - 1 - l) : l) * 16 + c * 8;
   endfunction

   function automatic int out_k_pos(input int l, input int c, input bit steer);
      return (steer ? (LANES - 1 - l) : l) * 2 + c;
   endfunction

   function automatic logic ctrl_ok(input logic [7:0] b);
      return (b == CODE_IDLE) || (b == CODE_S) || (b == CODE_T) ||
             (b == CODE_Q) || (b == CODE_E);
   endfunction

   // One column: idle columns become A/K/R, others pass with control sanitising.
   function automatic col_res_t col_map(input logic        en,
                                        input logic [31:0] d,
                                        input logic [3:0]  c,
                                        input logic [6:0]  prbs,
                                        input logic [4:0]  a_cnt,
                                        input logic [4:0]  a_base);
      col_res_t   r;
      logic       idle;
      logic [7:0] b;
      r    = '0;
      b    = '0;
      idle = !en || ((c == 4'hF) && (d == {4{CODE_IDLE}}));
      if (idle) begin
         r.k = 4'hF;
         if (a_cnt == 5'd0) begin
            r.bytes  = {4{CODE_A}};
            r.a_next = a_base + {1'b0, prbs[3:0]};
            r.a_sent = 1'b1;
         end else begin
            r.bytes  = prbs[0] ? {4{CODE_K}} : {4{CODE_R}};
            r.a_next = a_cnt - 5'd1;
         end
      end else begin
         // A zero count is held so the pending ||A|| lands on the next idle column.
         r.a_next = (a_cnt == 5'd0) ? 5'd0 : a_cnt - 5'd1;
         r.k      = c;
         for (int l = 0; l < LANES; l++) begin
            b = d[l*8 +: 8];
            if (!c[l])
               r.bytes[l*8 +: 8] = b;
            else if (b == CODE_IDLE)
               r.bytes[l*8 +: 8] = CODE_K;
            else if (ctrl_ok(b))
               r.bytes[l*8 +: 8] = b;
            else
               r.bytes[l*8 +: 8] = CODE_E;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xaui_prbs7.sv
`default_nettype none
// xaui_prbs7: one step of the x^7+x^6+1 PRBS; next_state[0] is the generated bit.
module xaui_prbs7 (
   input  logic [6:0] state,
   output logic [6:0] next_state
);

   assign next_state = {state[5:0], state[6] ^ state[5]};

endmodule
`default_nettype wire

// File: rtl/xaui_tx_idle_gen.sv
`default_nettype none
// xaui_tx_idle_gen: XGMII quad (2 columns/cycle) to GTX txdata/txcharisk with XAUI idle
// randomisation. Define XAUI_TX_LANE_STEER_EN to reverse output lane order.
module xaui_tx_idle_gen
   import xaui_pkg::*;
#(
   parameter int         A_MIN     = 16,
   parameter logic [6:0] PRBS_SEED = 7'h7F
) (
   input  logic        xaui_clk,
   input  logic        mgt_tx_rst,
   input  logic        tx_en,
   input  logic [63:0] xgmii_txd,
   input  logic [7:0]  xgmii_txc,
   output logic [63:0] mgt_txdata,
   output logic [7:0]  mgt_txcharisk,
   output logic [15:0] align_cnt
);

`ifdef XAUI_TX_LANE_STEER_EN
   localparam bit STEER = 1'b1;
`else
   localparam bit STEER = 1'b0;
`endif

   // A_MIN-1+15 must fit the 5-bit counter, so A_MIN is limited to 17.
   localparam logic [4:0] A_BASE = 5'(A_MIN - 1);

   logic [6:0]  prbs_q;
   logic [6:0]  prbs_mid;
   logic [6:0]  prbs_nxt;
   logic [4:0]  a_cnt_q;
   col_res_t    res0;
   col_res_t    res1;
   logic [63:0] data_nxt;
   logic [7:0]  k_nxt;

   xaui_prbs7 u_prbs_col0 (.state(prbs_q),   .next_state(prbs_mid));
   xaui_prbs7 u_prbs_col1 (.state(prbs_mid), .next_state(prbs_nxt));

   always_comb begin
      res0 = col_map(tx_en, xgmii_txd[txd_pos(0, 0) +: 32], xgmii_txc[3:0],
                     prbs_q, a_cnt_q, A_BASE);
      res1 = col_map(tx_en, xgmii_txd[txd_pos(1, 0) +: 32], xgmii_txc[7:4],
                     prbs_mid, res0.a_next, A_BASE);
      data_nxt = '0;
      k_nxt    = '0;
      for (int l = 0; l < LANES; l++) begin
         data_nxt[out_byte_pos(l, 0, STEER) +: 8] = res0.bytes[l*8 +: 8];
         data_nxt[out_byte_pos(l, 1, STEER) +: 8] = res1.bytes[l*8 +: 8];
         k_nxt[out_k_pos(l, 0, STEER)]            = res0.k[l];
         k_nxt[out_k_pos(l, 1, STEER)]            = res1.k[l];
      end
   end

   always_ff @(posedge xaui_clk) begin
      if (mgt_tx_rst) begin
         prbs_q        <= PRBS_SEED;
         a_cnt_q       <= 5'd0;
         mgt_txdata    <= {8{CODE_K}};
         mgt_txcharisk <= 8'hFF;
         align_cnt     <= 16'd0;
      end else begin
         prbs_q        <= prbs_nxt;
         a_cnt_q       <= res1.a_next;
         mgt_txdata    <= data_nxt;
         mgt_txcharisk <= k_nxt;
         align_cnt     <= align_cnt + 16'(res0.a_sent) + 16'(res1.a_sent);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xaui_tx_idle_gen.sv
`default_nettype none
// tb_xaui_tx_idle_gen: scoreboard + vector-table bench for xaui_tx_idle_gen.
`timescale 1ns/1ps
module tb_xaui_tx_idle_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_en = 1'b0;
   logic [63:0] txd = '0;
   logic [7:0]  txc = '0;
   logic [63:0] mgt_txdata;
   logic [7:0]  mgt_txcharisk;
   logic [15:0] align_cnt;

   always #5 clk = ~clk;

   xaui_tx_idle_gen #(.A_MIN(16), .PRBS_SEED(7'h7F)) dut (
      .xaui_clk      (clk),
      .mgt_tx_rst    (rst),
      .tx_en         (tx_en),
      .xgmii_txd     (txd),
      .xgmii_txc     (txc),
      .mgt_txdata    (mgt_txdata),
      .mgt_txcharisk (mgt_txcharisk),
      .align_cnt     (align_cnt)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic [15:0] a;
   } exp_t;

   typedef struct {
      logic [63:0] txd;
      logic [7:0]  txc;
      logic [31:0] e0;
      logic [3:0]  k0;
      logic [31:0] e1;
      logic [3:0]  k1;
   } vec_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;

   logic [6:0]  m_prbs = 7'h7F;
   logic [4:0]  m_acnt = 5'd0;
   logic [15:0] m_align = 16'd0;

   logic        tab_on = 1'b0;
   logic [63:0] tab_d = '0;
   logic [7:0]  tab_k = '0;

   int          col_idx = 0;
   int          last_a = -1;
   int          obs_a = 0;
   logic        spacing_on = 1'b0;
   logic        a_in_cycle = 1'b0;
   logic        a_in_col0 = 1'b0;

   localparam logic [63:0] IDLE_D = {8{8'h07}};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   function automatic int phys(input int l);
`ifdef XAUI_TX_LANE_STEER_EN
      return 3 - l;
`else
      return l;
`endif
   endfunction

   task automatic pack(input logic [31:0] b0, input logic [3:0] k0,
                       input logic [31:0] b1, input logic [3:0] k1,
                       output logic [63:0] d, output logic [7:0] k);
      d = '0;
      k = '0;
      for (int l = 0; l < 4; l++) begin
         d[phys(l)*16 +: 8]     = b0[l*8 +: 8];
         d[phys(l)*16 + 8 +: 8] = b1[l*8 +: 8];
         k[phys(l)*2]           = k0[l];
         k[phys(l)*2 + 1]       = k1[l];
      end
   endtask

   function automatic logic col_is_a(input logic [63:0] d, input logic [7:0] k, input int c);
      logic r;
      r = 1'b1;
      for (int l = 0; l < 4; l++)
         if (d[phys(l)*16 + c*8 +: 8] != 8'h7C || !k[phys(l)*2 + c]) r = 1'b0;
      return r;
   endfunction

   // Reference column model: golden PRBS7 from the seed and the A spacing counter.
   task automatic model_col(input logic en, input logic [31:0] d, input logic [3:0] c,
                            output logic [31:0] ob, output logic [3:0] ok);
      logic       idle;
      logic [7:0] b;
      idle = !en || (c == 4'hF && d == 32'h07070707);
      ob = '0;
      ok = '0;
      if (idle) begin
         ok = 4'hF;
         if (m_acnt == 0) begin
            ob = 32'h7C7C7C7C;
            m_acnt = 5'd15 + {1'b0, m_prbs[3:0]};
            m_align = m_align + 16'd1;
         end else begin
            ob = m_prbs[0] ? 32'hBCBCBCBC : 32'h1C1C1C1C;
            m_acnt = m_acnt - 5'd1;
         end
      end else begin
         if (m_acnt != 0) m_acnt = m_acnt - 5'd1;
         for (int l = 0; l < 4; l++) begin
            b = d[l*8 +: 8];
            ok[l] = c[l];
            if (!c[l]) ob[l*8 +: 8] = b;
            else if (b == 8'h07) ob[l*8 +: 8] = 8'hBC;
            else if (b == 8'hFB || b == 8'hFD || b == 8'h9C || b == 8'hFE) ob[l*8 +: 8] = b;
            else ob[l*8 +: 8] = 8'hFE;
         end
      end
      m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_empty: actual 0 entries required 1");
         return;
      end
      e = sb.pop_front();
      chk("txdata", mgt_txdata, e.d);
      chk("txcharisk", {56'b0, mgt_txcharisk}, {56'b0, e.k});
      chk("align_cnt", {48'b0, align_cnt}, {48'b0, e.a});
      a_in_cycle = 1'b0;
      a_in_col0  = col_is_a(mgt_txdata, mgt_txcharisk, 0);
      for (int c = 0; c < 2; c++) begin
         if (col_is_a(mgt_txdata, mgt_txcharisk, c)) begin
            a_in_cycle = 1'b1;
            obs_a++;
            if (spacing_on && last_a >= 0)
               chk("a_spacing_16_31", 64'((col_idx - last_a) >= 16 && (col_idx - last_a) <= 31), 64'd1);
            last_a = col_idx;
         end
         col_idx++;
      end
   endtask

   task automatic cycle(input logic r, input logic en, input logic [63:0] d, input logic [7:0] c);
      exp_t        e;
      logic [31:0] b0, b1;
      logic [3:0]  k0, k1;
      @(negedge clk);
      rst = r;
      tx_en = en;
      txd = d;
      txc = c;
      if (r) begin
         m_prbs = 7'h7F;
         m_acnt = 5'd0;
         m_align = 16'd0;
         e.d = 64'hBCBC_BCBC_BCBC_BCBC;
         e.k = 8'hFF;
         e.a = 16'd0;
      end else begin
         model_col(en, d[31:0], c[3:0], b0, k0);
         model_col(en, d[63:32], c[7:4], b1, k1);
         pack(b0, k0, b1, k1, e.d, e.k);
         e.a = m_align;
      end
      if (tab_on) begin
         e.d = tab_d;
         e.k = tab_k;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
      if (r) begin
         obs_a = 0;
         last_a = -1;
         col_idx = 0;
      end
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{64'h44332211_D55555FB, 8'h01, 32'hD55555FB, 4'h1, 32'h44332211, 4'h0};
      vecs[1] = '{64'h88776655_44332211, 8'h00, 32'h44332211, 4'h0, 32'h88776655, 4'h0};
      vecs[2] = '{64'h0707FDEE_DDCCBBAA, 8'hE0, 32'hDDCCBBAA, 4'h0, 32'hBCBCFDEE, 4'hE};
      vecs[3] = '{64'h80706050_40552010, 8'h04, 32'h40FE2010, 4'h4, 32'h80706050, 4'h0};
      vecs[4] = '{64'h030201FE_0100009C, 8'h11, 32'h0100009C, 4'h1, 32'h030201FE, 4'h1};
      vecs[5] = '{64'hF7020100_3322FB07, 8'h83, 32'h3322FBBC, 4'h3, 32'hFE020100, 4'h8};

      // Reset, then forced idle with garbage on the XGMII inputs.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, '0);
      spacing_on = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b0, {$urandom, $urandom}, 8'($urandom));
         if (i == 0) chk("first_col0_is_A", 64'(a_in_col0), 64'd1);
      end
      chk("align_cnt_vs_seen", {48'b0, align_cnt}, 64'(obs_a));
      spacing_on = 1'b0;

      // Vector table: fully non-idle columns, expectations fixed in the table.
      for (int i = 0; i < 6; i++) begin
         tab_on = 1'b1;
         pack(vecs[i].e0, vecs[i].k0, vecs[i].e1, vecs[i].k1, tab_d, tab_k);
         cycle(1'b0, 1'b1, vecs[i].txd, vecs[i].txc);
         tab_on = 1'b0;
         if (i == 1) begin
`ifdef XAUI_TX_LANE_STEER_EN
            chk("steer_byte", {56'b0, mgt_txdata[55:48]}, 64'h11);
            chk("steer_k", {63'b0, mgt_txcharisk[6]}, 64'd0);
`else
            chk("lane0_byte", {56'b0, mgt_txdata[7:0]}, 64'h11);
            chk("lane0_k", {63'b0, mgt_txcharisk[0]}, 64'd0);
`endif
         end
      end

      // Idle detected from the XGMII input itself.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, IDLE_D, 8'hFF);

      // Pending ||A||: 40 data columns, then the first idle column must be ||A||.
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, {$urandom, $urandom} & 64'hFFFFFF00_FFFFFF00, 8'h00);
         chk("no_A_in_data", 64'(a_in_cycle), 64'd0);
      end
      cycle(1'b0, 1'b1, IDLE_D, 8'hFF);
      chk("pending_A_col0", 64'(a_in_col0), 64'd1);

      // Reset in the middle of a packet.
      cycle(1'b0, 1'b1, 64'h12345678_9ABCDE00, 8'h00);
      cycle(1'b1, 1'b1, 64'h0BADF00D_0BADF00D, 8'h00);
      chk("rst_mid_data", mgt_txdata, 64'hBCBC_BCBC_BCBC_BCBC);
      chk("rst_mid_k", {56'b0, mgt_txcharisk}, 64'hFF);
      cycle(1'b0, 1'b1, IDLE_D, 8'hFF);
      chk("post_rst_A_col0", 64'(a_in_col0), 64'd1);

      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, {$urandom, $urandom}, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/xaui_tx_idle_gen.md
Name: xaui_tx_idle_gen

Overview:
- Transmit-side companion to the GTX XAUI receive path: converts one XGMII-style quad stream (2 columns per cycle) into GTX `mgt_txdata`/`mgt_txcharisk` for one quad.
- Replaces XGMII idle columns with the XAUI randomized ||A||/||K||/||R|| idle sequence.
- Passes data and control codes through.
- One instance per quad; output feeds `mgt_txdata[I*64+:64]` and `mgt_txcharisk[I*8+:8]`.

Parameters:
- A_MIN, 16, minimum columns between ||A|| columns (reload base).
- PRBS_SEED, 7'h7F, PRBS7 reset value; must be non-zero.

Ports:
- xaui_clk  in  1  TX user clock; all logic on rising edge.
- mgt_tx_rst  in  1  synchronous active-high reset.
- tx_en  in  1  1 = pass XGMII input; 0 = force idle sequence.
- xgmii_txd  in  64  column c (0 = earlier), lane l byte at [c*32+l*8+:8].
- xgmii_txc  in  8  control flag for the same byte at [c*4+l].
- mgt_txdata  out  64  lane l column c byte at [l*16+c*8+:8].
- mgt_txcharisk  out  8  K flag at [l*2+c].
- align_cnt  out  16  count of ||A|| columns sent, wraps at 0xFFFF.

Behaviour:
- **Pipeline:** single register stage, latency 1 cycle, no backpressure, throughput 2 columns every cycle.
- **Column processing:** columns are processed in order col0 then col1 within a cycle. Col1 sees the PRBS and A-counter state updated by col0.
- **PRBS7:** polynomial x^7+x^6+1, 7-bit state.
  - new bit = s[6]^s[5]; s <= {s[5:0], new}.
  - Advances exactly once per column (twice per cycle), regardless of column type.
- **A counter (a_cnt, 5 bits):** decrements by 1 per column, saturating at 0.
- **Idle column:** all 4 lanes have txc=1 and byte 8'h07, or tx_en=0. It is output as one of the following, all 4 lanes with charisk=1:
  - a_cnt==0 -> ||A||: 8'h7C (K28.3). Reload a_cnt = A_MIN-1 + prbs[3:0] (range 15..30, i.e. next A after 16..31 columns). Increment align_cnt.
  - else prbs[0]==1 -> ||K||: 8'hBC (K28.5).
  - else -> ||R||: 8'h1C (K28.0).
  - Decision uses the PRBS state before that column's advance.
- **Non-idle column:** copied lane by lane; charisk = txc.
  - A control byte other than 8'h07, 8'hFB (S), 8'hFD (T), 8'h9C (Q) or 8'hFE (E) is replaced by 8'hFE with charisk=1.
  - An 8'h07 byte in a mixed column (e.g. after T) becomes 8'hBC with charisk=1.
- **Pending A:** a_cnt==0 during a non-idle column does not reload; ||A|| goes out on the next idle column.
- **tx_en:**
  - Sampled per cycle; when 0, both columns are treated as idle irrespective of xgmii inputs.
  - A transition mid-packet truncates the packet; no T is inserted.
- **Reset:**
  - Outputs: mgt_txdata = 64'hBCBC_BCBC_BCBC_BCBC, mgt_txcharisk = 8'hFF, align_cnt = 0.
  - Internal state: prbs = PRBS_SEED, a_cnt = 0, so the first idle column after reset is ||A||.
  - Reset asserted mid-packet takes effect on the next edge: output becomes the reset value and the packet is dropped.
- **Simultaneous:** if both columns in a cycle are idle with a_cnt==0 at col0, col0 = ||A||; col1 uses the reloaded a_cnt-1 and so is never ||A||.

Optional Feature:
- Macro: XAUI_TX_LANE_STEER_EN.
- **Defined:** output lanes reversed to compensate for XAUI crossover.
  - Lane 0 is driven on mgt_txdata[63:48] / mgt_txcharisk[7:6]; lane 3 on [15:0] / [1:0].
  - Column order within a lane is unchanged.
- **Undefined:** lane l on [l*16+:16] / [l*2+:2] as above. No other behaviour changes.

Decomposition:
- **Package xaui_pkg:** code constants (IDLE 8'h07, A 8'h7C, K 8'hBC, R 8'h1C, S 8'hFB, T 8'hFD, Q 8'h9C, E 8'hFE) and the column/lane index helpers.
- **Sub-module xaui_prbs7:** step function/module producing next state and output bit. It is instantiated twice in series for the two columns.

Test Plan:
- **Reset idle:** reset then tx_en=0 for 40 cycles.
  - Cycle 1 after reset: col0 = ||A|| (7C x4, charisk 8'hFF).
  - Subsequent ||A|| spacing always 16..31 columns.
  - K/R pattern matches a golden PRBS7 model from seed 7F.
  - align_cnt matches the number of A columns seen.
- **Packet passthrough:** tx_en=1, input S,D...,T,I columns.
  - Data bytes appear 1 cycle later with charisk=0 at remapped positions.
  - S = FB/K, T = FD/K; /I/ bytes after T become BC/K.
- **Pending A:** hold a non-idle stream for 40 columns.
  - No ||A|| during the data.
  - The first idle column after the data is ||A||.
- **Invalid control:** txc=1 with byte 8'h55 in lane 2 -> output byte FE with charisk=1 for that lane only.
- **Reset mid-packet:** assert mgt_tx_rst during data.
  - Next cycle outputs BCBC_BCBC_BCBC_BCBC / FF.
  - After release, the first idle column is ||A||.
- **Steering:** with XAUI_TX_LANE_STEER_EN, send lane0 = 8'h11 (col0) -> appears at mgt_txdata[55:48] with charisk[6]=0.
